// File: rtl/div_unit_pkg.sv
// Shared width and state encoding for the radix-2 restoring divider.
// Imported by the divider interface and the divider itself.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage and the divider.
// The master drives operands and control; the slave returns stall and results.
interface div_if
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);
   logic             start;
   logic             signed_div;
   logic             annul;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, signed_div, annul, a, b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, signed_div, annul, a, b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to lo, remainder to hi.
// One quotient bit per RUN cycle; magnitudes are divided and signs fixed on the last step.
//
// state    | meaning
// DIV_IDLE | waiting for start; operands captured (as magnitudes for DIV) on start
// DIV_RUN  | WIDTH shift/subtract steps; annul returns to IDLE without a result
// DIV_DONE | one-cycle done pulse; hi/lo/div_by_zero were committed entering this state
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)(
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic             q_neg;
   logic             r_neg;
   logic             zero_pend;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] neg_a_in;
   logic [WIDTH-1:0] neg_b_in;
   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;

   // r < dvs always holds, so a set diff MSB means borrow unless r_shift itself overflowed WIDTH bits.
   always_comb begin
      r_shift = {r, dvd[WIDTH-1]};
      diff    = r_shift - {1'b0, dvs};
      ge      = r_shift[WIDTH] | ~diff[WIDTH];
      r_nxt   = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], ge};
   end

   // Negators are shared: operand magnitudes in IDLE, result sign fix on the last RUN step.
   always_comb begin
      neg_a_in = (state == DIV_IDLE) ? bus.a : q_nxt;
      neg_b_in = (state == DIV_IDLE) ? bus.b : r_nxt;
      neg_a    = -neg_a_in;
      neg_b    = -neg_b_in;
   end

   assign bus.busy = ((state == DIV_IDLE) && bus.start && !bus.annul) || (state == DIV_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= DIV_IDLE;
         count           <= '0;
         dvd             <= '0;
         dvs             <= '0;
         r               <= '0;
         q               <= '0;
         q_neg           <= 1'b0;
         r_neg           <= 1'b0;
         zero_pend       <= 1'b0;
         bus.done        <= 1'b0;
         bus.hi          <= '0;
         bus.lo          <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (bus.start && !bus.annul) begin
                  state     <= DIV_RUN;
                  count     <= '0;
                  r         <= '0;
                  q         <= '0;
                  zero_pend <= (bus.b == '0);
                  if (bus.signed_div) begin
                     dvd   <= bus.a[WIDTH-1] ? neg_a : bus.a;
                     dvs   <= bus.b[WIDTH-1] ? neg_b : bus.b;
                     q_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                     r_neg <= bus.a[WIDTH-1];
                  end else begin
                     dvd   <= bus.a;
                     dvs   <= bus.b;
                     q_neg <= 1'b0;
                     r_neg <= 1'b0;
                  end
               end
            end
            DIV_RUN: begin
               if (bus.annul) begin
                  state <= DIV_IDLE;
               end else begin
                  r     <= r_nxt;
                  q     <= q_nxt;
                  dvd   <= {dvd[WIDTH-2:0], 1'b0};
                  count <= count + 1'b1;
                  if (count == LAST) begin
                     state           <= DIV_DONE;
                     bus.done        <= 1'b1;
                     bus.lo          <= zero_pend ? '1 : (q_neg ? neg_a : q_nxt);
                     bus.hi          <= r_neg ? neg_b : r_nxt;
                     bus.div_by_zero <= zero_pend;
                  end
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: latency, sign rules, divide-by-zero, annul and reset.
// Expected results are queued at start and popped when done pulses.
module tb_div_unit;
   import div_unit_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [64:0] exp_q[$];
   logic [64:0] last_exp;

   div_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {div_by_zero, hi, lo}
   function automatic logic [64:0] model(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] qv;
      logic [31:0] rv;
      if (bv == 32'd0) begin
         qv = 32'hFFFF_FFFF;
         rv = av;
      end else if (sgn && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
         qv = 32'h8000_0000;
         rv = 32'd0;
      end else if (sgn) begin
         qv = $signed(av) / $signed(bv);
         rv = $signed(av) % $signed(bv);
      end else begin
         qv = av / bv;
         rv = av % bv;
      end
      return {(bv == 32'd0), rv, qv};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1ns after a rising edge; that cycle becomes cycle 0 of the op.
   task automatic do_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv, input bit poke);
      logic [64:0] e;
      int n;
      exp_q.push_back(model(sgn, av, bv));
      bus.start      = 1'b1;
      bus.signed_div = sgn;
      bus.a          = av;
      bus.b          = bv;
      #1 chk("busy_start", {31'd0, bus.busy}, 32'd1);
      tick();
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      n = 1;
      while (!bus.done && n < 40) begin
         chk("busy_run", {31'd0, bus.busy}, 32'd1);
         if (poke && n == 5) begin
            bus.start      = 1'b1;
            bus.signed_div = ~sgn;
         end
         tick();
         bus.start = 1'b0;
         n++;
      end
      chk("latency", 32'(n), 32'd33);
      chk("done", {31'd0, bus.done}, 32'd1);
      chk("busy_done", {31'd0, bus.busy}, 32'd0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         last_exp = e;
         chk("lo", bus.lo, e[31:0]);
         chk("hi", bus.hi, e[63:32]);
         chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e[64]});
      end else begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end
      tick();
      chk("done_pulse", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      logic        sgn;
      logic [31:0] ra;
      logic [31:0] rb;
      total = 0;
      bad   = 0;
      last_exp       = '0;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.annul      = 1'b0;
      bus.a          = 32'd0;
      bus.b          = 32'd0;
      tick();
      tick();
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      rst = 1'b0;
      tick();

      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      chk("divu_100_7_lo", bus.lo, 32'd14);
      chk("divu_100_7_hi", bus.hi, 32'd2);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      chk("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
      chk("div_7_m2_hi", bus.hi, 32'd1);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf_lo", bus.lo, 32'h8000_0000);
      chk("div_ovf_hi", bus.hi, 32'd0);
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("divu_big_lo", bus.lo, 32'd0);
      chk("divu_big_hi", bus.hi, 32'h8000_0000);
      do_op(1'b0, 32'd5, 32'd0, 1'b0);
      chk("dbz_lo", bus.lo, 32'hFFFF_FFFF);
      chk("dbz_hi", bus.hi, 32'd5);
      chk("dbz_flag", {31'd0, bus.div_by_zero}, 32'd1);
      do_op(1'b0, 32'd100, 32'd7, 1'b0);
      chk("dbz_cleared", {31'd0, bus.div_by_zero}, 32'd0);
      do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'd0, 1'b0);

      // annul in cycle 10 of a divide
      bus.start      = 1'b1;
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k < 10; k++) begin
         chk("annul_no_done", {31'd0, bus.done}, 32'd0);
         tick();
      end
      bus.annul = 1'b1;
      chk("annul_busy_c10", {31'd0, bus.busy}, 32'd1);
      tick();
      bus.annul = 1'b0;
      chk("annul_busy_c11", {31'd0, bus.busy}, 32'd0);
      chk("annul_done_c11", {31'd0, bus.done}, 32'd0);
      chk("annul_lo_kept", bus.lo, last_exp[31:0]);
      chk("annul_hi_kept", bus.hi, last_exp[63:32]);
      tick();
      do_op(1'b0, 32'd100, 32'd7, 1'b0);

      // reset in cycle 20 of a divide
      bus.start      = 1'b1;
      bus.signed_div = 1'b1;
      bus.a          = 32'hFFFF_F000;
      bus.b          = 32'd3;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k < 20; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_dbz", {31'd0, bus.div_by_zero}, 32'd0);

      // start and annul together in IDLE
      bus.start = 1'b1;
      bus.annul = 1'b1;
      #1 chk("start_annul_busy", {31'd0, bus.busy}, 32'd0);
      tick();
      bus.start = 1'b0;
      bus.annul = 1'b0;
      for (int k = 0; k < 36; k++) begin
         chk("start_annul_idle", {31'd0, bus.busy | bus.done}, 32'd0);
         tick();
      end

      for (int i = 0; i < 300; i++) begin
         sgn = 1'($urandom_range(0, 1));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 3 == 0) begin
            rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) rb = -rb;
         end
         if (rb == 32'd0) rb = 32'd1;
         do_op(sgn, ra, rb, 1'b0);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
